// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one variable-latency memory port (ext > data > fetch, fetch starvation guard).
// Define MEM_PORT_ARBITER_PERF_EN to add the fetch/data grant and stall-cycle performance counters.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    input  logic        ext_req,
    input  logic        ext_wr,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] ext_rdata,
    output logic        ext_valid,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        cpu_stall,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    typedef enum logic [1:0] {P_NONE, P_IF, P_D, P_EXT} port_t;

    state_t             state_q, state_d;
    port_t              win_q, win_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_wr_q, mem_wr_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic [31:0]        ext_rdata_q, ext_rdata_d;
    logic               if_valid_q, if_valid_d;
    logic               d_valid_q, d_valid_d;
    logic               ext_valid_q, ext_valid_d;
    logic               err_q, err_d;

    logic               fetch_forced;
    logic               resp_done;
    logic [31:0]        resp_data;

    assign fetch_forced = if_req && (starve_q == STV_W'(STARVE_LIMIT));

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tmo_d       = tmo_q;
        starve_d    = starve_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        ext_rdata_d = ext_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        ext_valid_d = 1'b0;
        err_d       = 1'b0;
        resp_done   = 1'b0;
        resp_data   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (ext_req) begin
                    win_d       = P_EXT;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = ext_wr;
                    mem_addr_d  = ext_addr;
                    mem_wdata_d = ext_wdata;
                    tmo_d       = '0;
                    state_d     = S_BUSY;
                end else if (d_req && !fetch_forced) begin
                    win_d       = P_D;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tmo_d       = '0;
                    state_d     = S_BUSY;
                    // only data grants that bypass a waiting fetch count toward starvation
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (if_req) begin
                    win_d       = P_IF;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                    starve_d    = '0;
                    state_d     = S_BUSY;
                end
            end

            S_BUSY: begin
                // ack wins over a timeout landing on the same cycle
                if (mem_ack) begin
                    resp_done = 1'b1;
                    resp_data = mem_rdata;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    resp_done = 1'b1;
                    resp_data = ERR_DATA;
                    err_d     = 1'b1;
                end

                if (resp_done) begin
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resp_done) begin
            unique case (win_q)
                P_IF: begin
                    if_rdata_d = resp_data;
                    if_valid_d = 1'b1;
                end
                P_D: begin
                    d_rdata_d = resp_data;
                    d_valid_d = 1'b1;
                end
                P_EXT: begin
                    ext_rdata_d = resp_data;
                    ext_valid_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_q       <= P_NONE;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            ext_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            ext_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tmo_q       <= tmo_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            ext_valid_q <= ext_valid_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign ext_valid = ext_valid_q;
    assign err       = err_q;

    // the host freezes the pipeline for as long as it owns the memory
    assign cpu_stall = (if_req && !if_valid_q) || (d_req && !d_valid_q) || (ext_req && !ext_valid_q);

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic        gnt_if, gnt_d;
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    assign gnt_if = (state_q == S_IDLE) && (win_d == P_IF) && (state_d == S_BUSY);
    assign gnt_d  = (state_q == S_IDLE) && (win_d == P_D) && (state_d == S_BUSY);

    always_comb begin
        perf_if_d    = perf_if_q + {31'd0, gnt_if};
        perf_d_d     = perf_d_q + {31'd0, gnt_d};
        perf_stall_d = perf_stall_q + {31'd0, cpu_stall};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_q    <= '0;
            perf_d_q     <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_if_q    <= perf_if_d;
            perf_d_q     <= perf_d_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_if_grants    = perf_if_q;
    assign perf_d_grants     = perf_d_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grants, latency and responses.
module tb_mem_port_arbiter;

    localparam int          LIM   = 4;
    localparam int          TMO   = 16;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, ext_req = 1'b0, ext_wr = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, ext_addr = '0, ext_wdata = '0;
    logic [31:0] if_rdata, d_rdata, ext_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, ext_valid, mem_req, mem_wr, cpu_stall, err;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_valid(ext_valid),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_stall(cpu_stall), .err(err)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          prob [3];
    bit          obs_v [3];

    // model: one outstanding transaction, described by its grant cycle and memory wait
    bit          t_active;
    int          t_port, t_g, t_w, t_v, next_grant, starve;
    logic        t_wr;
    logic [31:0] t_addr, t_wdata, ack_data;
    bit          known [3];
    logic [31:0] kval [3];
    int          n_timeouts = 0, n_forced = 0;

    // memory responder
    bit          mem_active;
    int          mem_k, cur_w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        t_active   = 1'b0;
        starve     = 0;
        next_grant = cyc + 1;
        mem_active = 1'b0;
        mem_ack    = 1'b0;
        cur_w      = NEVER;
        for (int i = 0; i < 3; i++) begin
            known[i] = 1'b1;
            kval[i]  = '0;
            obs_v[i] = 1'b0;
        end
    endtask

    task automatic drive_reqs();
        if (if_req && obs_v[0]) if_req = 1'b0;
        if (!if_req && int'($urandom_range(0, 99)) < prob[0]) begin
            if_req  = 1'b1;
            if_addr = $urandom;
        end
        if (d_req && obs_v[1]) d_req = 1'b0;
        if (!d_req && int'($urandom_range(0, 99)) < prob[1]) begin
            d_req   = 1'b1;
            d_wr    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
        if (ext_req && obs_v[2]) ext_req = 1'b0;
        if (!ext_req && int'($urandom_range(0, 99)) < prob[2]) begin
            ext_req   = 1'b1;
            ext_wr    = 1'($urandom_range(0, 1));
            ext_addr  = $urandom;
            ext_wdata = $urandom;
        end
    endtask

    task automatic drive_mem();
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_k      = 0;
            end
            mem_ack = (mem_k == cur_w);
            if (mem_ack) ack_data = mem_rdata;
            mem_k++;
        end else begin
            mem_active = 1'b0;
            mem_ack    = 1'b0;
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 8)  return r % 4;
        if (r < 12) return 0;
        if (r < 14) return TMO - 1;
        return NEVER;
    endfunction

    task automatic model_and_check();
        bit   ev [3];
        bit   exp_mreq, exp_err, exp_stall;
        int   eff;
        logic [31:0] got_rd [3];
        got_rd[0] = if_rdata;
        got_rd[1] = d_rdata;
        got_rd[2] = ext_rdata;
        ev[0] = 1'b0; ev[1] = 1'b0; ev[2] = 1'b0;
        exp_mreq = 1'b0;
        exp_err  = 1'b0;
        if (t_active) begin
            eff      = (t_w > TMO - 1) ? TMO - 1 : t_w;
            exp_mreq = (cyc >= t_g + 1) && (cyc <= t_g + 1 + eff);
            if (cyc == t_v) begin
                ev[t_port] = 1'b1;
                exp_err    = (t_w > TMO - 1);
                if (exp_err) n_timeouts++;
                if (t_wr) begin
                    known[t_port] = 1'b0;
                end else begin
                    known[t_port] = 1'b1;
                    kval[t_port]  = exp_err ? ERRD : ack_data;
                end
            end
        end

        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
        if (exp_mreq) begin
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, t_wr});
            if (t_wr) chk("mem_wdata", mem_wdata, t_wdata);
        end
        chk("if_valid", {31'd0, if_valid}, {31'd0, ev[0]});
        chk("d_valid", {31'd0, d_valid}, {31'd0, ev[1]});
        chk("ext_valid", {31'd0, ext_valid}, {31'd0, ev[2]});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        if (known[0]) chk("if_rdata", got_rd[0], kval[0]);
        if (known[1]) chk("d_rdata", got_rd[1], kval[1]);
        if (known[2]) chk("ext_rdata", got_rd[2], kval[2]);
        exp_stall = (if_req && !ev[0]) || (d_req && !ev[1]) || (ext_req && !ev[2]);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});

        obs_v[0] = if_valid;
        obs_v[1] = d_valid;
        obs_v[2] = ext_valid;

        if (t_active && cyc == t_v) begin
            t_active   = 1'b0;
            next_grant = cyc + 1;
        end else if (!t_active && cyc >= next_grant) begin
            t_port = -1;
            if (ext_req) begin
                t_port = 2;
            end else if (d_req && !(starve == LIM && if_req)) begin
                t_port = 1;
                starve = if_req ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            end else if (if_req) begin
                if (d_req) n_forced++;
                t_port = 0;
                starve = 0;
            end
            if (t_port >= 0) begin
                unique case (t_port)
                    0: begin t_addr = if_addr;  t_wr = 1'b0;   t_wdata = '0;        end
                    1: begin t_addr = d_addr;   t_wr = d_wr;   t_wdata = d_wdata;   end
                    default: begin t_addr = ext_addr; t_wr = ext_wr; t_wdata = ext_wdata; end
                endcase
                t_g      = cyc;
                t_w      = pick_wait();
                eff      = (t_w > TMO - 1) ? TMO - 1 : t_w;
                t_v      = t_g + 2 + eff;
                cur_w    = t_w;
                t_active = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        drive_reqs();
        drive_mem();
        @(negedge clk);
        model_and_check();
    endtask

    initial begin
        bit hit;
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_ext_valid", {31'd0, ext_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_ext_rdata", ext_rdata, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        prob[0] = 30; prob[1] = 30; prob[2] = 10;
        repeat (2000) step();

        // fetch and data both saturating the port
        prob[0] = 100; prob[1] = 100; prob[2] = 0;
        repeat (400) step();
        chk("starve_forced_fetch_seen", {31'd0, n_forced > 0}, 32'd1);

        // asynchronous reset while the memory is busy
        prob[0] = 0; prob[1] = 100; prob[2] = 0;
        hit = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (t_active && cyc > t_g && cyc < t_v) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_busy", {31'd0, hit}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("async_rst_err", {31'd0, err}, 32'd0);
        prob[1] = 0;
        if_req = 1'b0; d_req = 1'b0; ext_req = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_hold_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_hold_d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) step();

        prob[0] = 40; prob[1] = 20; prob[2] = 20;
        repeat (1000) step();
        chk("timeouts_seen", {31'd0, n_timeouts > 0}, 32'd1);

        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between three requesters:
  - the CPU instruction-fetch port;
  - the CPU data (MEM-stage) port;
  - an external host/loader port.
- Sits between the CPU top level and the memory controller.
- Sequences one transaction at a time through a request/ack FSM.
- Drives a pipeline stall while any CPU access is outstanding.
- Applies fixed priority (ext > data > fetch), with a starvation guard that protects fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced to win.
- TIMEOUT, 16: cycles to wait for mem_ack before aborting the transaction.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_valid
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_rdata  out  32  read data
- d_valid  out  1  one-cycle data completion pulse
- ext_req  in  1  host request; held until ext_valid
- ext_wr  in  1  host write
- ext_addr  in  32  host address
- ext_wdata  in  32  host write data
- ext_rdata  out  32  host read data
- ext_valid  out  1  one-cycle host completion pulse
- mem_req  out  1  memory request, registered
- mem_wr  out  1  memory write enable, registered
- mem_addr  out  32  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- cpu_stall  out  1  stall request to the pipeline
- err  out  1  one-cycle timeout pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FSM returns to IDLE.
  - All outputs are 0, including mem_req, valids, err and rdata registers.
  - Starvation and timeout counters are 0.
  - Reset in the middle of a transaction drops mem_req immediately; the transaction is lost and no valid pulse is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Evaluate the requests present this cycle and pick a winner:
    - ext_req wins first.
    - d_req wins next, unless starve_cnt == STARVE_LIMIT and if_req is high; in that case fetch wins.
    - if_req wins last.
  - On a grant: latch the winner ID, mem_addr, mem_wr and mem_wdata; set mem_req = 1 on the next edge; go to BUSY.
  - Fetch grants are always reads (mem_wr = 0).
- BUSY:
  - mem_* outputs are held stable.
  - tmo_cnt increments every cycle.
  - On mem_ack: capture mem_rdata into the winner's rdata register, drop mem_req, go to RESP.
  - If tmo_cnt reaches TIMEOUT-1 without an ack: drop mem_req, load ERR_DATA, pulse err, go to RESP.
  - An ack arriving on the same cycle as the timeout counts as success.
- RESP:
  - Pulse the winner's valid for exactly one cycle.
  - Return to IDLE.
- Minimum latency: grant cycle, plus one BUSY cycle with an ack in the same cycle, plus RESP. That gives 3 cycles from request to valid; the back-to-back issue rate is one transaction per 3 cycles.
- Writes also produce a valid pulse. The rdata of the write winner is then undefined but stable.
- Starvation counter:
  - Increments on each data grant made while if_req = 1.
  - Clears on any fetch grant, and whenever if_req = 0 at grant time.
  - Saturates at STARVE_LIMIT.
- Ext grants do not affect starve_cnt.
- rdata registers of non-winning ports hold their previous values.
- cpu_stall = (if_req & ~if_valid) | (d_req & ~d_valid) | ext_busy, where ext_busy = ext_req & ~ext_valid. The host holds the CPU frozen while it owns memory.
- Requests that drop before their valid pulse are a protocol violation. The transaction completes regardless.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- When defined, add three outputs:
  - perf_if_grants (32): count of fetch grants.
  - perf_d_grants (32): count of data grants.
  - perf_stall_cycles (32): count of cycles with cpu_stall = 1.
- All three counters reset to 0, wrap modulo 2^32, and are read-only.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single fetch, read:
  - Stimulus: if_req = 1 with if_addr = 0x100; memory acks 1 cycle after mem_req with 0x1234_5678.
  - Response: if_valid pulses 3 cycles after the request, with if_rdata = 0x1234_5678; cpu_stall is high until that cycle.
- Simultaneous requests:
  - Stimulus: if_req, d_req and ext_req all asserted at the same time.
  - Response: grant order is ext, then data, then fetch; each valid appears as a single pulse, 3 cycles apart with 0-wait acks.
- Starvation guard:
  - Stimulus: if_req and d_req held continuously, with d_req re-asserted immediately after each d_valid.
  - Response: with STARVE_LIMIT = 4, four data grants occur, then a fetch grant, then the counter clears.
- Timeout:
  - Stimulus: a data read to 0x200 with mem_ack never asserted.
  - Response: mem_req drops after 16 cycles; err and d_valid pulse together with d_rdata = 0xDEAD_BEEF.
- Data write:
  - Stimulus: d_wr = 1, d_addr = 0x40, d_wdata = 0xA5A5_A5A5, ack after a 3-cycle wait.
  - Response: mem_wr = 1, mem_addr = 0x40 and mem_wdata = 0xA5A5_A5A5 are held stable through BUSY; d_valid pulses once.
- Reset mid-transaction:
  - Stimulus: rst_n asserted low during BUSY.
  - Response: mem_req goes to 0 without waiting for a clock edge; no valid pulse; the FSM is in IDLE after release.
